// File: rtl/vending_core_param.sv
// Parametrised vending core: credit register, per-item stock, inactivity timer
// and a greedy change dispenser driven by run-time coin values and item prices.
module vending_core_param #(
  parameter int NUM_COINS   = 3,
  parameter int NUM_ITEMS   = 4,
  parameter int TOTAL_BITS  = 31,
  parameter int WAIT_CYCLES = 100,
  parameter int STOCK_BITS  = 4,
  parameter int INIT_STOCK  = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic [NUM_ITEMS-1:0]            i_select_item,
  input  logic                            i_trigger_return,
  input  logic                            i_restock,
  input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value,
  input  logic [NUM_ITEMS*TOTAL_BITS-1:0] item_price,
  output logic [NUM_ITEMS-1:0]            o_available_item,
  output logic [NUM_ITEMS-1:0]            o_output_item,
  output logic [NUM_COINS-1:0]            o_return_coin,
  output logic                            o_coin_reject,
  output logic                            o_change_err,
  output logic [TOTAL_BITS-1:0]           o_current_total,
  output logic                            o_busy
);

  localparam int SUM_W   = TOTAL_BITS + $clog2(NUM_COINS + 1);
  localparam int TIMER_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RETURN} state_t;

  state_t                  r_state;
  logic [TOTAL_BITS-1:0]   r_credit;
  logic [TIMER_W-1:0]      r_timer;
  logic [STOCK_BITS-1:0]   r_stock [NUM_ITEMS];
  logic [NUM_ITEMS-1:0]    r_outputItem;
  logic [NUM_COINS-1:0]    r_returnCoin;
  logic                    r_coinReject;
  logic                    r_changeErr;

  logic [SUM_W-1:0]        w_coinSum;
  logic [SUM_W-1:0]        w_creditSum;
  logic                    w_overflow;
  logic                    w_anyCoin;
  logic                    w_coinAccept;
  logic [NUM_ITEMS-1:0]    w_dispHot;
  logic [TOTAL_BITS-1:0]   w_dispPrice;
  logic                    w_dispense;
  logic [NUM_COINS-1:0]    w_chgHot;
  logic [TOTAL_BITS-1:0]   w_chgValue;
  logic                    w_chgFound;

  // Coin sum is kept wide enough that credit + sum can never wrap silently.
  always_comb begin
    w_coinSum = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (i_input_coin[i]) begin
        w_coinSum = w_coinSum + SUM_W'(coin_value[i*TOTAL_BITS +: TOTAL_BITS]);
      end
    end
  end

  assign w_creditSum  = SUM_W'(r_credit) + w_coinSum;
  assign w_overflow   = |w_creditSum[SUM_W-1:TOTAL_BITS];
  assign w_anyCoin    = |i_input_coin;
  assign w_coinAccept = w_anyCoin && !w_overflow;

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      o_available_item[i] = (r_state == S_ACTIVE) && (r_stock[i] != '0) &&
                            (item_price[i*TOTAL_BITS +: TOTAL_BITS] <= r_credit);
    end
  end

  // Descending scan so the lowest selected, available item wins.
  always_comb begin
    w_dispHot   = '0;
    w_dispPrice = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (i_select_item[i] && o_available_item[i]) begin
        w_dispHot    = '0;
        w_dispHot[i] = 1'b1;
        w_dispPrice  = item_price[i*TOTAL_BITS +: TOTAL_BITS];
      end
    end
  end
  assign w_dispense = |w_dispHot;

  // Ascending coin values, so the last fitting coin is the largest one.
  always_comb begin
    w_chgHot   = '0;
    w_chgValue = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin_value[i*TOTAL_BITS +: TOTAL_BITS] <= r_credit) begin
        w_chgHot    = '0;
        w_chgHot[i] = 1'b1;
        w_chgValue  = coin_value[i*TOTAL_BITS +: TOTAL_BITS];
      end
    end
  end
  assign w_chgFound = |w_chgHot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_credit     <= '0;
      r_timer      <= '0;
      r_outputItem <= '0;
      r_returnCoin <= '0;
      r_coinReject <= 1'b0;
      r_changeErr  <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_BITS'(INIT_STOCK);
    end else begin
      r_outputItem <= '0;
      r_returnCoin <= '0;
      r_coinReject <= 1'b0;
      r_changeErr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_anyCoin) begin
            if (w_overflow) begin
              r_coinReject <= 1'b1;
            end else begin
              r_state  <= S_ACTIVE;
              r_credit <= w_creditSum[TOTAL_BITS-1:0];
              r_timer  <= TIMER_W'(WAIT_CYCLES);
            end
          end
        end
        S_ACTIVE: begin
          if (i_trigger_return) begin
            r_state      <= S_RETURN;
            r_coinReject <= w_anyCoin;
          end else begin
            r_outputItem <= w_dispHot;
            r_coinReject <= w_anyCoin && w_overflow;
            r_credit     <= (w_coinAccept ? w_creditSum[TOTAL_BITS-1:0] : r_credit) -
                            (w_dispense ? w_dispPrice : '0);
            if (w_coinAccept || w_dispense) begin
              r_timer <= TIMER_W'(WAIT_CYCLES);
            end else if (r_timer == '0) begin
              r_state <= S_RETURN;
            end else begin
              r_timer <= r_timer - TIMER_W'(1);
            end
          end
        end
        S_RETURN: begin
          r_coinReject <= w_anyCoin;
          if (r_credit == '0) begin
            r_state <= S_IDLE;
          end else if (w_chgFound) begin
            r_returnCoin <= w_chgHot;
            r_credit     <= r_credit - w_chgValue;
          end else begin
            r_credit    <= '0;
            r_changeErr <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Restock overrides a same-cycle dispense decrement.
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (i_restock) begin
          r_stock[i] <= STOCK_BITS'(INIT_STOCK);
        end else if (r_state == S_ACTIVE && !i_trigger_return && w_dispHot[i]) begin
          r_stock[i] <= r_stock[i] - STOCK_BITS'(1);
        end
      end
    end
  end

  assign o_output_item   = r_outputItem;
  assign o_return_coin   = r_returnCoin;
  assign o_coin_reject   = r_coinReject;
  assign o_change_err    = r_changeErr;
  assign o_current_total = r_credit;
  assign o_busy          = (r_state == S_RETURN);

endmodule

// File: tb/tb_vending_core_param.sv
// Directed and randomized checks of vending_core_param against a cycle-level
// model computed from the vending rules with plain integer arithmetic.
module tb_vending_core_param;

  localparam int NC   = 3;
  localparam int NI   = 4;
  localparam int TW   = 31;
  localparam int WAIT = 3;
  localparam int SB   = 4;
  localparam int INIT = 8;

  localparam int MODE_IDLE   = 0;
  localparam int MODE_ACTIVE = 1;
  localparam int MODE_RETURN = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NC-1:0]     coin = '0;
  logic [NI-1:0]     sel = '0;
  logic              trig = 1'b0;
  logic              restock = 1'b0;
  logic [NC*TW-1:0]  coinVec;
  logic [NI*TW-1:0]  priceVec;
  logic [NI-1:0]     o_available_item;
  logic [NI-1:0]     o_output_item;
  logic [NC-1:0]     o_return_coin;
  logic              o_coin_reject;
  logic              o_change_err;
  logic [TW-1:0]     o_current_total;
  logic              o_busy;

  int compared = 0;
  int mismatched = 0;

  longint coinVal [NC];
  longint price [NI];
  int     mMode;
  longint mCredit;
  int     mTimer;
  int     mStock [NI];
  logic [NI-1:0] eOut;
  logic [NC-1:0] eRet;
  logic          eRej;
  logic          eErr;

  vending_core_param #(
    .NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TW),
    .WAIT_CYCLES(WAIT), .STOCK_BITS(SB), .INIT_STOCK(INIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_input_coin(coin),
    .i_select_item(sel),
    .i_trigger_return(trig),
    .i_restock(restock),
    .coin_value(coinVec),
    .item_price(priceVec),
    .o_available_item(o_available_item),
    .o_output_item(o_output_item),
    .o_return_coin(o_return_coin),
    .o_coin_reject(o_coin_reject),
    .o_change_err(o_change_err),
    .o_current_total(o_current_total),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic loadValues();
    for (int i = 0; i < NC; i++) coinVec[i*TW +: TW] = TW'(coinVal[i]);
    for (int i = 0; i < NI; i++) priceVec[i*TW +: TW] = TW'(price[i]);
  endtask

  task automatic modelReset();
    mMode = MODE_IDLE;
    mCredit = 0;
    mTimer = 0;
    for (int i = 0; i < NI; i++) mStock[i] = INIT;
    eOut = '0;
    eRet = '0;
    eRej = 1'b0;
    eErr = 1'b0;
  endtask

  function automatic logic [NI-1:0] modelAvail();
    logic [NI-1:0] a;
    a = '0;
    for (int i = 0; i < NI; i++)
      a[i] = (mMode == MODE_ACTIVE) && (mStock[i] > 0) && (price[i] <= mCredit);
    return a;
  endfunction

  // Advances the model by one clock edge from the rules of the machine.
  task automatic modelStep(input logic [NC-1:0] c, input logic [NI-1:0] s,
                           input logic t, input logic r);
    longint sum;
    longint limit;
    logic [NI-1:0] avail;
    int pick;
    bit fits;
    sum = 0;
    for (int i = 0; i < NC; i++) if (c[i]) sum += coinVal[i];
    limit = longint'(1) << TW;
    fits = (mCredit + sum) < limit;
    avail = modelAvail();
    eOut = '0;
    eRet = '0;
    eRej = 1'b0;
    eErr = 1'b0;
    if (mMode == MODE_IDLE) begin
      if (c != '0) begin
        if (!fits) eRej = 1'b1;
        else begin
          mMode = MODE_ACTIVE;
          mCredit += sum;
          mTimer = WAIT;
        end
      end
    end else if (mMode == MODE_ACTIVE) begin
      if (t) begin
        mMode = MODE_RETURN;
        eRej = (c != '0);
      end else begin
        pick = -1;
        for (int i = NI - 1; i >= 0; i--) if (s[i] && avail[i]) pick = i;
        eRej = (c != '0) && !fits;
        if (c != '0 && fits) mCredit += sum;
        if (pick >= 0) begin
          mCredit -= price[pick];
          eOut[pick] = 1'b1;
          mStock[pick]--;
        end
        if ((c != '0 && fits) || pick >= 0) mTimer = WAIT;
        else if (mTimer == 0) mMode = MODE_RETURN;
        else mTimer--;
      end
    end else begin
      eRej = (c != '0);
      if (mCredit == 0) mMode = MODE_IDLE;
      else if (mCredit < coinVal[0]) begin
        mCredit = 0;
        eErr = 1'b1;
        mMode = MODE_IDLE;
      end else begin
        pick = 0;
        for (int i = 0; i < NC; i++) if (coinVal[i] <= mCredit) pick = i;
        eRet[pick] = 1'b1;
        mCredit -= coinVal[pick];
      end
    end
    if (r) for (int i = 0; i < NI; i++) mStock[i] = INIT;
  endtask

  task automatic checkAll();
    checkOutput("outputItem", 64'(o_output_item), 64'(eOut));
    checkOutput("returnCoin", 64'(o_return_coin), 64'(eRet));
    checkOutput("coinReject", 64'(o_coin_reject), 64'(eRej));
    checkOutput("changeErr", 64'(o_change_err), 64'(eErr));
    checkOutput("currentTotal", 64'(o_current_total), 64'(mCredit));
    checkOutput("busy", 64'(o_busy), 64'(mMode == MODE_RETURN));
  endtask

  task automatic applyStimulus(input logic [NC-1:0] c, input logic [NI-1:0] s,
                               input logic t, input logic r);
    coin = c;
    sel = s;
    trig = t;
    restock = r;
    #1;
    checkOutput("available", 64'(o_available_item), 64'(modelAvail()));
    modelStep(c, s, t, r);
    @(posedge clk);
    #1;
    coin = '0;
    sel = '0;
    trig = 1'b0;
    restock = 1'b0;
    checkAll();
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("resetAvail", 64'(o_available_item), 64'd0);
    checkAll();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    coinVal = '{100, 500, 1000};
    price = '{400, 500, 1000, 2000};
    loadValues();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetAvail", 64'(o_available_item), 64'd0);
    checkAll();
    reset_n = 1'b1;

    $display("[TB] coin insertion and availability");
    applyStimulus(3'b010, '0, 1'b0, 1'b0);
    applyStimulus(3'b100, '0, 1'b0, 1'b0);
    checkOutput("credit1500", 64'(o_current_total), 64'd1500);
    checkOutput("avail0111", 64'(o_available_item), 64'b0111);

    $display("[TB] priority dispense and refund");
    applyStimulus('0, 4'b0011, 1'b0, 1'b0);
    checkOutput("dispenseItem0", 64'(o_output_item), 64'b0001);
    checkOutput("credit1100", 64'(o_current_total), 64'd1100);
    applyStimulus('0, '0, 1'b1, 1'b0);
    checkOutput("busyEnter", 64'(o_busy), 64'd1);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("change1000", 64'(o_return_coin), 64'b100);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("change100", 64'(o_return_coin), 64'b001);
    checkOutput("credit0", 64'(o_current_total), 64'd0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("busyLeave", 64'(o_busy), 64'd0);

    $display("[TB] inactivity timeout");
    applyStimulus(3'b001, '0, 1'b0, 1'b0);
    repeat (WAIT) applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("timeoutNotYet", 64'(o_busy), 64'd0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("timeoutReturn", 64'(o_busy), 64'd1);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("timeoutRefund", 64'(o_return_coin), 64'b001);
    applyStimulus('0, '0, 1'b0, 1'b0);

    $display("[TB] credit overflow");
    coinVal[2] = (longint'(1) << TW) - 50;
    loadValues();
    applyStimulus(3'b100, '0, 1'b0, 1'b0);
    applyStimulus(3'b001, '0, 1'b0, 1'b0);
    checkOutput("overflowReject", 64'(o_coin_reject), 64'd1);
    checkOutput("overflowCredit", 64'(o_current_total), (64'd1 << TW) - 64'd50);
    applyStimulus('0, '0, 1'b1, 1'b0);
    repeat (2) applyStimulus('0, '0, 1'b0, 1'b0);
    coinVal[2] = 1000;
    loadValues();

    $display("[TB] unpayable residual credit");
    applyStimulus(3'b001, '0, 1'b0, 1'b0);
    coinVal[0] = 200;
    loadValues();
    applyStimulus('0, '0, 1'b1, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("changeErrPulse", 64'(o_change_err), 64'd1);
    checkOutput("changeErrCredit", 64'(o_current_total), 64'd0);
    coinVal[0] = 100;
    loadValues();

    $display("[TB] stock exhaustion and restock");
    applyReset();
    for (int k = 0; k < INIT; k++) begin
      applyStimulus(3'b010, '0, 1'b0, 1'b0);
      applyStimulus('0, 4'b0001, 1'b0, 1'b0);
    end
    applyStimulus(3'b010, '0, 1'b0, 1'b0);
    checkOutput("soldOut", 64'(o_available_item[0]), 64'd0);
    applyStimulus('0, '0, 1'b0, 1'b1);
    checkOutput("restocked", 64'(o_available_item[0]), 64'd1);
    applyStimulus('0, '0, 1'b1, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("midReturnBusy", 64'(o_busy), 64'd1);
    applyReset();

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 2) == 0) ? NC'($urandom) : '0,
                    ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 29) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
